coincidence_counter: RTL and testbench
======================================

Name: coincidence_counter

Overview:
Sits directly downstream of the per-channel delay stage and consumes its aligned channel outputs. Over a programmable integration window it counts rising-edge events per channel (singles) and same-cycle coincidences for every channel pair. At the end of the window it streams the results out one word per transfer over a valid/ready interface. Events arriving during readout are dead time and are not counted.

Parameters:
NCHAN, 4, number of channels; must be at least 2.
CBITS, 32, width of each singles and coincidence counter and of OutData.
PBITS, 32, width of the integration period input.
Localparam NPAIRS = NCHAN*(NCHAN-1)/2.
Localparam NWORDS = NCHAN + NPAIRS.
Localparam IBITS = clog2(NWORDS), minimum 1.

Ports:
Clk        input   1       single clock; all logic on the rising edge.
Rst_n      input   1       asynchronous, active-low reset.
DlayChann  input   NCHAN   aligned channel levels from the delay stage.
Start      input   1       one-cycle request to begin an integration.
Period     input   PBITS   integration length in Clk cycles; sampled when Start is accepted.
Busy       output  1       high in any state other than IDLE.
OutData    output  CBITS   result word.
OutIdx     output  IBITS   index of the current result word.
OutLast    output  1       high with the final word (OutIdx = NWORDS-1).
OutValid   output  1       OutData, OutIdx and OutLast are valid.
OutReady   input   1       the consumer accepts the word.

Behaviour:
- Reset, asynchronous:
  - state = IDLE; all counters, the period counter, OutIdx and the previous-sample register are 0.
  - Busy = 0, OutValid = 0, OutData = 0, OutLast = 0.
- Edge detect:
  - prev[NCHAN-1:0] samples DlayChann every cycle in every state.
  - ev[i] = DlayChann[i] & ~prev[i].
  - A level already high when COUNT is entered is not an event.
- IDLE:
  - Start = 1 at edge T: clear all counters, latch Period into the period counter, go to COUNT at T+1.
  - If Period = 0, go to DUMP instead and report all-zero words.
  - In any state other than IDLE, Start is ignored.
- COUNT:
  - Lasts exactly Period cycles, from T+1 to T+Period inclusive. ev is evaluated in each of those cycles.
  - single[i] increments when ev[i] = 1.
  - pair[p] increments when both channels of the pair have ev = 1 in the same cycle.
  - Pair order: (0,1), (0,2) … (0,N-1), (1,2) … (N-2,N-1).
  - All counters saturate at 2^CBITS-1 and never wrap.
  - The period counter decrements each cycle. In the cycle where it reaches 1, that cycle's events are still counted and the next state is DUMP.
- DUMP:
  - On entry, OutValid = 1 and OutIdx = 0.
  - OutData is a registered output: single[OutIdx] for indices 0..NCHAN-1, then pair[OutIdx-NCHAN] for indices NCHAN..NWORDS-1.
  - A transfer occurs when OutValid & OutReady on a rising edge; OutIdx then advances by 1 and OutData updates in the same edge.
  - Without OutReady, OutData, OutIdx and OutLast hold stable. OutValid never drops without a transfer.
  - The transfer with OutLast = 1 clears OutValid, and the state returns to IDLE on the next cycle. Start is first accepted in that IDLE cycle.
  - Counters are frozen; DlayChann edges are not counted.
- Busy is registered and equals (state != IDLE).
- A Rst_n assertion at any point, including mid-COUNT or mid-DUMP, aborts immediately to reset values. There is no partial readout.
- FSM: IDLE -> COUNT -> DUMP -> IDLE, plus IDLE -> DUMP when Period = 0.

Test Plan:
1. Reset, then idle with Start = 0 for 20 cycles -> Busy = 0, OutValid = 0, OutData = 0 throughout.
2. Period = 100. Ch0 gets 5 separate 1-cycle pulses, ch2 gets 3, and ch0/ch2 are coincident on 2 of those pulses. OutReady held at 1 -> 10 words in order: singles 5,0,3,0; pairs (0,1)=0, (0,2)=2, all other pairs 0. OutLast on OutIdx 9. Busy is high for 100 + 10 cycles.
3. Same stimulus as 2 with OutReady toggling 1 cycle on / 3 cycles off -> identical word sequence. Data and index are stable while stalled. Exactly 10 transfers.
4. CBITS = 4, Period = 40, ch1 toggling every cycle (20 rising edges) -> single[1] = 15 (saturated), all other words 0.
5. ch3 held high before Start and through COUNT, Period = 10 -> single[3] = 0. A Start pulsed mid-COUNT is ignored: period unchanged, counters unchanged.
6. Rst_n low during DUMP at OutIdx = 4 -> OutValid = 0 and Busy = 0 asynchronously. After release and a new Start with Period = 0 -> immediate DUMP of 10 zero words.

Source files
------------

// File: rtl/coincidence_counter.sv
// coincidence_counter: per-channel singles and pairwise same-cycle coincidence
// counting over a programmable window, followed by a valid/ready readout of
// all counters (singles first, then pairs in lexicographic order).
`timescale 1ns/1ps
module coincidence_counter #(
  parameter int unsigned NCHAN = 4,
  parameter int unsigned CBITS = 32,
  parameter int unsigned PBITS = 32,
  localparam int unsigned NPAIRS = NCHAN * (NCHAN - 1) / 2,
  localparam int unsigned NWORDS = NCHAN + NPAIRS,
  localparam int unsigned IBITS = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [NCHAN-1:0] DlayChann,
  input  logic             Start,
  input  logic [PBITS-1:0] Period,
  output logic             Busy,
  output logic [CBITS-1:0] OutData,
  output logic [IBITS-1:0] OutIdx,
  output logic             OutLast,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DUMP  = 2'd2;

  localparam logic [CBITS-1:0] CMAX = '1;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [NCHAN-1:0]  prev;
  logic [NCHAN-1:0]  ev;
  logic [NPAIRS-1:0] pair_hit;
  logic [PBITS-1:0]  per_cnt;
  logic [IBITS-1:0]  idx_inc;
  logic              start_ok;
  logic              count_end;
  logic              xfer;

  logic [CBITS-1:0] single_q   [NCHAN];
  logic [CBITS-1:0] single_nxt [NCHAN];
  logic [CBITS-1:0] pair_q     [NPAIRS];
  logic [CBITS-1:0] pair_nxt   [NPAIRS];
  logic [CBITS-1:0] word_nxt   [NWORDS];

  assign ev        = DlayChann & ~prev;
  assign start_ok  = (state == S_IDLE) && Start;
  assign count_end = (state == S_COUNT) && (per_cnt == PBITS'(1));
  assign xfer      = OutValid && OutReady;
  assign idx_inc   = OutIdx + IBITS'(1);

  // Pair coincidence flags; pair (i,j) lands at its lexicographic position
  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_pi
    for (genvar gj = gi + 1; gj < NCHAN; gj++) begin : g_pj
      localparam int unsigned P = gi * (2 * NCHAN - gi - 1) / 2 + (gj - gi - 1);
      assign pair_hit[P] = ev[gi] & ev[gj];
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = (Period == '0) ? S_DUMP : S_COUNT;
      S_COUNT: if (per_cnt == PBITS'(1)) state_nxt = S_DUMP;
      S_DUMP:  if (xfer && OutLast) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Saturating counter increments for the current cycle's events
  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      single_nxt[i] = single_q[i];
      if ((state == S_COUNT) && ev[i] && (single_q[i] != CMAX))
        single_nxt[i] = single_q[i] + CBITS'(1);
    end
    for (int p = 0; p < NPAIRS; p++) begin
      pair_nxt[p] = pair_q[p];
      if ((state == S_COUNT) && pair_hit[p] && (pair_q[p] != CMAX))
        pair_nxt[p] = pair_q[p] + CBITS'(1);
    end
  end

  // Readout word map, including events of the final counting cycle
  always_comb begin
    for (int i = 0; i < NCHAN; i++) word_nxt[i] = single_nxt[i];
    for (int p = 0; p < NPAIRS; p++) word_nxt[NCHAN + p] = pair_nxt[p];
  end

  // Edge-detect history, sampled in every state
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) prev <= '0;
    else        prev <= DlayChann;
  end

  // State register and busy flag
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
      Busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      Busy  <= (state_nxt != S_IDLE);
    end
  end

  // Integration period countdown
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                  per_cnt <= '0;
    else if (start_ok)           per_cnt <= Period;
    else if (state == S_COUNT)   per_cnt <= per_cnt - PBITS'(1);
  end

  // Singles and pair counters: cleared on start, frozen outside COUNT
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NCHAN; i++) single_q[i] <= '0;
      for (int p = 0; p < NPAIRS; p++) pair_q[p] <= '0;
    end else if (start_ok) begin
      for (int i = 0; i < NCHAN; i++) single_q[i] <= '0;
      for (int p = 0; p < NPAIRS; p++) pair_q[p] <= '0;
    end else if (state == S_COUNT) begin
      for (int i = 0; i < NCHAN; i++) single_q[i] <= single_nxt[i];
      for (int p = 0; p < NPAIRS; p++) pair_q[p] <= pair_nxt[p];
    end
  end

  // Readout stream: load word 0 on DUMP entry, advance on each transfer
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      OutValid <= 1'b0;
      OutIdx   <= '0;
      OutData  <= '0;
      OutLast  <= 1'b0;
    end else if (start_ok && (Period == '0)) begin
      OutValid <= 1'b1;
      OutIdx   <= '0;
      OutData  <= '0;
      OutLast  <= 1'b0;
    end else if (count_end) begin
      OutValid <= 1'b1;
      OutIdx   <= '0;
      OutData  <= word_nxt[0];
      OutLast  <= 1'b0;
    end else if ((state == S_DUMP) && xfer) begin
      if (OutLast) begin
        OutValid <= 1'b0;
        OutIdx   <= '0;
        OutData  <= '0;
        OutLast  <= 1'b0;
      end else begin
        OutIdx  <= idx_inc;
        OutData <= word_nxt[idx_inc];
        OutLast <= (idx_inc == IBITS'(NWORDS - 1));
      end
    end
  end

endmodule

// File: tb/tb_coincidence_counter.sv
// Bench for coincidence_counter: scoreboard of expected readout words built
// from the driven channel patterns, checked as the DUT streams them out.
`timescale 1ns/1ps
module tb_coincidence_counter;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
  } word_t;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic        OutReady;
  logic [3:0]  DlayChann;
  logic [31:0] Period;

  logic        busy_a, valid_a, last_a;
  logic [31:0] data_a;
  logic [3:0]  idx_a;
  logic        busy_b, valid_b, last_b;
  logic [3:0]  data_b;
  logic [3:0]  idx_b;

  int    n_checks = 0;
  int    n_errors = 0;
  int    busy_tot = 0;
  int    xfer_tot = 0;
  int    rmode    = 0;
  int    rcyc     = 0;
  bit    en_b     = 0;
  bit    hold_v   = 0;
  logic [31:0] hold_d;
  logic [3:0]  hold_i;
  word_t qa[$];
  word_t qb[$];
  word_t wa, wb;

  coincidence_counter #(.NCHAN(4), .CBITS(32), .PBITS(32)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .DlayChann(DlayChann), .Start(Start), .Period(Period),
    .Busy(busy_a), .OutData(data_a), .OutIdx(idx_a), .OutLast(last_a),
    .OutValid(valid_a), .OutReady(OutReady)
  );

  coincidence_counter #(.NCHAN(4), .CBITS(4), .PBITS(32)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .DlayChann(DlayChann), .Start(Start), .Period(Period),
    .Busy(busy_b), .OutData(data_b), .OutIdx(idx_b), .OutLast(last_b),
    .OutValid(valid_b), .OutReady(OutReady)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Channel stimulus per test mode and count-cycle index
  function automatic logic [3:0] pat(input int mode, input int c);
    logic [3:0] v;
    v = '0;
    case (mode)
      2: begin
        v[0] = (c == 10 || c == 20 || c == 30 || c == 40 || c == 50);
        v[2] = (c == 20 || c == 40 || c == 70);
      end
      4: v[1] = (c % 2 == 0);
      5: begin
        v[3] = 1'b1;
        v[0] = (c == 2 || c == 6);
      end
      6: begin
        v[0] = (c == 3 || c == 8);
        v[1] = (c == 5);
        v[2] = (c == 5);
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Ready driver: always ready, or one cycle on / three off
  initial begin
    OutReady = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      rcyc++;
      OutReady = (rmode == 0) ? 1'b1 : (rcyc % 4 == 0);
    end
  end

  // Busy cycle tally
  always @(negedge Clk) if (busy_a) busy_tot++;

  // Scoreboard for the 32-bit DUT, with stall-stability checks
  always @(negedge Clk) begin
    if (!Rst_n) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        check("stall_data", data_a, hold_d);
        check("stall_idx", idx_a, hold_i);
        hold_v = 0;
      end
      if (valid_a && OutReady) begin
        if (qa.size() == 0) begin
          check("extra_word_a", 64'(qa.size()), 64'd1);
        end else begin
          wa = qa.pop_front();
          check("word_data_a", data_a, wa.data);
          check("word_idx_a", idx_a, wa.idx);
          check("word_last_a", last_a, 64'(wa.idx == 4'd9));
          xfer_tot++;
        end
      end else if (valid_a) begin
        hold_v = 1;
        hold_d = data_a;
        hold_i = idx_a;
      end
    end
  end

  // Scoreboard for the 4-bit DUT, enabled for the saturation test
  always @(negedge Clk) begin
    if (Rst_n && en_b && valid_b && OutReady) begin
      if (qb.size() == 0) begin
        check("extra_word_b", 64'(qb.size()), 64'd1);
      end else begin
        wb = qb.pop_front();
        check("word_data_b", data_b, wb.data[3:0]);
        check("word_idx_b", idx_b, wb.idx);
        check("word_last_b", last_b, 64'(wb.idx == 4'd9));
      end
    end
  end

  // Build expected words from the pattern, then drive Start and the window
  task automatic start_window(input int per, input int mode, input bit use_b);
    int s[4];
    int pr[6];
    int p;
    int cnt;
    logic [3:0] pv, cv;
    word_t w;
    for (int i = 0; i < 4; i++) s[i] = 0;
    for (int i = 0; i < 6; i++) pr[i] = 0;
    pv = DlayChann;
    for (int c = 0; c < per; c++) begin
      cv = pat(mode, c);
      p = 0;
      for (int i = 0; i < 4; i++) begin
        if (cv[i] && !pv[i]) s[i]++;
        for (int j = i + 1; j < 4; j++) begin
          if (cv[i] && !pv[i] && cv[j] && !pv[j]) pr[p]++;
          p++;
        end
      end
      pv = cv;
    end
    for (int k = 0; k < 10; k++) begin
      cnt = (k < 4) ? s[k] : pr[k-4];
      w.data = 32'(cnt);
      w.idx  = 4'(k);
      qa.push_back(w);
      if (use_b) begin
        w.data = 32'((cnt > 15) ? 15 : cnt);
        qb.push_back(w);
      end
    end
    @(posedge Clk);
    #1;
    Period = 32'(per);
    Start  = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    for (int c = 0; c < per; c++) begin
      DlayChann = pat(mode, c);
      Start = (mode == 5 && c == 4);
      if (mode == 5 && c == 4) Period = 32'd77;
      @(posedge Clk);
      #1;
    end
    DlayChann = '0;
    Start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (k < 400 && (busy_a || qa.size() != 0 || qb.size() != 0)) begin
      @(negedge Clk);
      k++;
    end
    check({tag, "_timeout"}, 64'(k < 400), 64'd1);
  endtask

  initial begin
    int b0, x0;
    Rst_n     = 1'b0;
    Start     = 1'b0;
    Period    = '0;
    DlayChann = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_last", last_a, 0);
    check("rst_idx", idx_a, 0);
    Rst_n = 1'b1;

    // Idle with no start
    repeat (20) begin
      @(negedge Clk);
      check("idle_a", {busy_a, valid_a, data_a}, 0);
      check("idle_b", {busy_b, valid_b, data_b}, 0);
    end

    // Singles and a (0,2) coincidence, always ready
    rmode = 0;
    b0 = busy_tot; x0 = xfer_tot;
    start_window(100, 2, 0);
    wait_done("t2");
    check("t2_busy_cycles", 64'(busy_tot - b0), 110);
    check("t2_xfers", 64'(xfer_tot - x0), 10);

    // Same stimulus with a stalling consumer
    rmode = 1;
    x0 = xfer_tot;
    start_window(100, 2, 0);
    wait_done("t3");
    check("t3_xfers", 64'(xfer_tot - x0), 10);
    rmode = 0;

    // Saturation on the 4-bit instance
    en_b = 1;
    b0 = busy_tot; x0 = xfer_tot;
    start_window(40, 4, 1);
    wait_done("t4");
    check("t4_busy_cycles", 64'(busy_tot - b0), 50);
    check("t4_xfers", 64'(xfer_tot - x0), 10);
    en_b = 0;

    // Pre-high level is no event; mid-count start ignored
    @(posedge Clk);
    #1;
    DlayChann = 4'b1000;
    repeat (3) @(posedge Clk);
    b0 = busy_tot; x0 = xfer_tot;
    start_window(10, 5, 0);
    wait_done("t5");
    check("t5_busy_cycles", 64'(busy_tot - b0), 20);
    check("t5_xfers", 64'(xfer_tot - x0), 10);

    // Async reset mid-readout, then a zero-length window
    start_window(20, 6, 0);
    begin
      int k;
      k = 0;
      while (k < 100 && !(valid_a && idx_a == 4'd4)) begin
        @(negedge Clk);
        k++;
      end
      check("t6_idx4_reached", idx_a, 4);
    end
    #2;
    Rst_n = 1'b0;
    #1;
    check("t6_async_valid", valid_a, 0);
    check("t6_async_busy", busy_a, 0);
    check("t6_async_idx", idx_a, 0);
    qa.delete();
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    b0 = busy_tot; x0 = xfer_tot;
    start_window(0, 0, 0);
    check("t6_p0_valid", valid_a, 1);
    check("t6_p0_idx", idx_a, 0);
    wait_done("t6");
    check("t6_busy_cycles", 64'(busy_tot - b0), 10);
    check("t6_xfers", 64'(xfer_tot - x0), 10);

    repeat (3) @(posedge Clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
